// File: rtl/dabus_pkg.sv
// Shared state encoding, beat width and byte-enable helper for the dabus packer.
package dabus_pkg;

    typedef enum logic {
        PACK  = 1'b0,
        FLUSH = 1'b1
    } state_t;

    localparam int BYTES_PER_BEAT = 8;

    // Byte count to an enable mask that is contiguous from bit 7; counts above 8 saturate.
    function automatic logic [7:0] cnt_to_be(input logic [3:0] cnt);
        logic [7:0] be;
        be = 8'h00;
        for (int i = 0; i < BYTES_PER_BEAT; i++) begin
            if (i < int'(cnt)) be[7-i] = 1'b1;
        end
        return be;
    endfunction

endpackage

// File: rtl/dabus_pack_if.sv
// Input (LSB-aligned, byte-counted) and output (MSB-aligned, byte-enabled) streams of the packer.
interface dabus_pack_if;

    logic        s_valid;
    logic        s_ready;
    logic [63:0] s_data;
    logic [3:0]  s_nbytes;
    logic        s_last;

    logic        m_valid;
    logic        m_ready;
    logic [63:0] m_data;
    logic [7:0]  m_be;
    logic        m_last;

    modport slave (
        input  s_valid, s_data, s_nbytes, s_last, m_ready,
        output s_ready, m_valid, m_data, m_be, m_last
    );

    modport master (
        output s_valid, s_data, s_nbytes, s_last, m_ready,
        input  s_ready, m_valid, m_data, m_be, m_last
    );

endinterface

// File: rtl/dabus_be_gen.sv
// Converts a byte count (0..8) into an MSB-contiguous byte enable.
module dabus_be_gen
    import dabus_pkg::*;
(
    input  logic [3:0] cnt,
    output logic [7:0] be
);

    assign be = cnt_to_be(cnt);

endmodule

// File: rtl/dabus_pack.sv
// Packs LSB-aligned variable-length beats into full MSB-aligned 8-byte words.
// Optional oversize detection (err port) is built when DABUS_PACK_ERRCHK_EN is defined.
module dabus_pack
    import dabus_pkg::*;
#(
    parameter int MAX_PKT_BEATS = 32
) (
    input  logic        clk,
    input  logic        rst_n,
    dabus_pack_if.slave bus
`ifdef DABUS_PACK_ERRCHK_EN
    ,
    output logic        err
`endif
);

    state_t        state;
    state_t        state_nxt;
    logic [63:0]   acc;
    logic [63:0]   acc_nxt;
    logic [2:0]    fill;
    logic [2:0]    fill_nxt;
    logic [3:0]    nin;
    logic [3:0]    total;
    logic [63:0]   in_msb;
    logic [127:0]  merged;
    logic          out_free;
    logic          accept;
    logic          load;
    logic          load_last;
    logic [63:0]   load_data;
    logic [3:0]    be_cnt;
    logic [7:0]    be_val;

    assign nin      = (bus.s_nbytes > 4'd8) ? 4'd8 : bus.s_nbytes;
    assign total    = {1'b0, fill} + nin;
    assign out_free = !bus.m_valid || bus.m_ready;
    assign accept   = bus.s_valid && bus.s_ready;

    // Left-justify the input bytes (dropping anything above nin), then slot them in behind the residual.
    assign in_msb = bus.s_data << (7'd64 - {nin, 3'b000});
    assign merged = {acc, 64'd0} | ({in_msb, 64'd0} >> {fill, 3'b000});

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= PACK;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            PACK:    if (accept && bus.s_last && total > 4'd8) state_nxt = FLUSH;
            FLUSH:   if (out_free) state_nxt = PACK;
            default: state_nxt = PACK;
        endcase
    end

    always_comb begin
        bus.s_ready = rst_n && (state == PACK) && out_free;
        load        = 1'b0;
        load_last   = 1'b0;
        load_data   = merged[127:64];
        be_cnt      = 4'd8;
        acc_nxt     = acc;
        fill_nxt    = fill;
        case (state)
            PACK: begin
                if (accept) begin
                    if (total >= 4'd8) begin
                        load      = 1'b1;
                        load_last = bus.s_last && (total == 4'd8);
                        acc_nxt   = merged[63:0];
                        fill_nxt  = total[2:0];
                    end else if (bus.s_last) begin
                        load      = 1'b1;
                        load_last = 1'b1;
                        be_cnt    = total;
                        acc_nxt   = 64'd0;
                        fill_nxt  = 3'd0;
                    end else begin
                        acc_nxt   = merged[127:64];
                        fill_nxt  = total[2:0];
                    end
                end
            end
            FLUSH: begin
                if (out_free) begin
                    load      = 1'b1;
                    load_last = 1'b1;
                    load_data = acc;
                    be_cnt    = {1'b0, fill};
                    acc_nxt   = 64'd0;
                    fill_nxt  = 3'd0;
                end
            end
            default: ;
        endcase
    end

    dabus_be_gen u_be_gen (
        .cnt (be_cnt),
        .be  (be_val)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc         <= 64'd0;
            fill        <= 3'd0;
            bus.m_valid <= 1'b0;
            bus.m_data  <= 64'd0;
            bus.m_be    <= 8'h00;
            bus.m_last  <= 1'b0;
        end else begin
            acc  <= acc_nxt;
            fill <= fill_nxt;
            if (load) begin
                bus.m_valid <= 1'b1;
                bus.m_data  <= load_data;
                bus.m_be    <= be_val;
                bus.m_last  <= load_last;
            end else if (bus.m_ready) begin
                bus.m_valid <= 1'b0;
            end
        end
    end

`ifdef DABUS_PACK_ERRCHK_EN
    localparam int CNT_W = $clog2(MAX_PKT_BEATS + 2);

    logic [CNT_W-1:0] beat_cnt;
    logic [CNT_W-1:0] cnt_base;

    // The closing handshake of a packet and the first load of the next can share a cycle.
    assign cnt_base = (bus.m_valid && bus.m_ready && bus.m_last) ? '0 : beat_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            beat_cnt <= '0;
            err      <= 1'b0;
        end else begin
            err <= load && (cnt_base == CNT_W'(MAX_PKT_BEATS));
            if (load && (cnt_base != CNT_W'(MAX_PKT_BEATS + 1))) begin
                beat_cnt <= cnt_base + 1'b1;
            end else begin
                beat_cnt <= cnt_base;
            end
        end
    end
`else
    localparam int unused_max_pkt_beats = MAX_PKT_BEATS;
`endif

endmodule

// File: tb/tb_dabus_pack.sv
// Scoreboard bench for dabus_pack: byte-queue reference model, directed cases and randomized packets.
module tb_dabus_pack;
    import dabus_pkg::*;

    localparam int MAXB = 4;

    typedef struct packed {
        logic [63:0] data;
        logic [7:0]  be;
        logic        last;
    } beat_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
`ifdef DABUS_PACK_ERRCHK_EN
    logic err;
    int   err_count = 0;
`endif

    int          tests = 0;
    int          failures = 0;
    int          ready_mode = 0;
    int          beat_count = 0;
    logic [63:0] last_data = '0;
    logic [7:0]  last_be = '0;
    logic        last_last = 1'b0;
    logic [7:0]  pkt_q[$];
    beat_t       exp_q[$];

    always #5 clk = ~clk;

    dabus_pack_if bus ();

    dabus_pack #(.MAX_PKT_BEATS(MAXB)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
`ifdef DABUS_PACK_ERRCHK_EN
        ,
        .err   (err)
`endif
    );

    function automatic void check(string name, logic [63:0] act, logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got %h, want %h", name, act, exp);
        end
    endfunction

    // Reference model: a packet is a byte stream; full words leave as soon as 8 bytes exist.
    function automatic void emit(int cnt, logic last);
        beat_t b;
        b = '0;
        b.last = last;
        for (int i = 0; i < cnt; i++) begin
            b.data[63-8*i -: 8] = pkt_q.pop_front();
            b.be[7-i] = 1'b1;
        end
        exp_q.push_back(b);
    endfunction

    function automatic void model_accept(logic [63:0] d, logic [3:0] nb, logic last);
        int   n;
        logic emitted;
        n = (nb > 4'd8) ? 8 : int'(nb);
        emitted = 1'b0;
        for (int i = n - 1; i >= 0; i--) pkt_q.push_back(d[8*i +: 8]);
        while (pkt_q.size() >= 8) begin
            emit(8, last && (pkt_q.size() == 8));
            emitted = 1'b1;
        end
        if (last && (pkt_q.size() > 0 || !emitted)) emit(pkt_q.size(), 1'b1);
    endfunction

    task automatic applyStimulus(input logic [63:0] d, input logic [3:0] nb, input logic last);
        int wait_cycles;
        wait_cycles = 0;
        bus.s_valid  = 1'b1;
        bus.s_data   = d;
        bus.s_nbytes = nb;
        bus.s_last   = last;
        forever begin
            @(negedge clk);
            if (bus.s_ready) begin
                model_accept(d, nb, last);
                break;
            end
            wait_cycles++;
            if (wait_cycles > 200) begin
                tests++;
                failures++;
                $display("[TB] FAIL s_ready_timeout: got no accept in %0d cycles, want accept", wait_cycles);
                break;
            end
        end
        @(posedge clk);
        #1;
        bus.s_valid = 1'b0;
    endtask

    task automatic checkOutput();
        beat_t e;
        beat_count++;
        last_data = bus.m_data;
        last_be   = bus.m_be;
        last_last = bus.m_last;
        if (exp_q.size() == 0) begin
            tests++;
            failures++;
            $display("[TB] FAIL unexpected_beat: got data %h be %h, want no beat", bus.m_data, bus.m_be);
        end else begin
            e = exp_q.pop_front();
            check("beat_data", bus.m_data, e.data);
            check("beat_be", 64'(bus.m_be), 64'(e.be));
            check("beat_last", 64'(bus.m_last), 64'(e.last));
        end
    endtask

    task automatic waitDrain();
        int n;
        n = 0;
        while ((exp_q.size() != 0 || bus.m_valid) && n < 500) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (n >= 500) begin
            tests++;
            failures++;
            $display("[TB] FAIL drain_timeout: got %0d beats outstanding, want 0", exp_q.size());
        end
    endtask

    // Output-ready driver, shifted off the stimulus timestep.
    initial begin
        bus.m_ready = 1'b0;
        forever begin
            @(posedge clk);
            #2;
            case (ready_mode)
                0:       bus.m_ready = 1'b1;
                1:       bus.m_ready = ($urandom_range(0, 3) != 0);
                default: bus.m_ready = 1'b0;
            endcase
        end
    end

    // Monitor: pops the scoreboard on every handshake and checks stability while stalled.
    initial begin
        logic        hold_valid;
        logic [63:0] hold_data;
        logic [7:0]  hold_be;
        logic        hold_last;
        int          pkt_idx;
        hold_valid = 1'b0;
        hold_data  = '0;
        hold_be    = '0;
        hold_last  = 1'b0;
        pkt_idx    = 0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                hold_valid = 1'b0;
                pkt_idx    = 0;
            end else begin
                if (hold_valid) begin
                    check("hold_valid", 64'(bus.m_valid), 64'd1);
                    check("hold_data", bus.m_data, hold_data);
                    check("hold_be", 64'(bus.m_be), 64'(hold_be));
                    check("hold_last", 64'(bus.m_last), 64'(hold_last));
                end
`ifdef DABUS_PACK_ERRCHK_EN
                check("err_pulse", 64'(err), 64'(bus.m_valid && !hold_valid && (pkt_idx == MAXB)));
                if (err) err_count++;
`endif
                if (bus.m_valid && bus.m_ready) begin
                    checkOutput();
                    if (bus.m_last) pkt_idx = 0;
                    else pkt_idx++;
                end
                hold_valid = bus.m_valid && !bus.m_ready;
                hold_data  = bus.m_data;
                hold_be    = bus.m_be;
                hold_last  = bus.m_last;
            end
        end
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: got no finish by %0t, want finish", $time);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [63:0] d;
        logic [3:0]  nb;
        int          nbeats;
        int          beats_before;
`ifdef DABUS_PACK_ERRCHK_EN
        int          errs_before;
`endif
        bus.s_valid  = 1'b0;
        bus.s_data   = '0;
        bus.s_nbytes = '0;
        bus.s_last   = 1'b0;

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_m_valid", 64'(bus.m_valid), 64'd0);
        check("rst_s_ready", 64'(bus.s_ready), 64'd0);
        check("rst_m_be", 64'(bus.m_be), 64'd0);
        @(posedge clk);
        #3;
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        applyStimulus(64'h1357_9BDF_0246_AABB, 4'd2, 1'b0);
        applyStimulus(64'hFFFF_FFFF_FFFF_CCDD, 4'd2, 1'b0);
        applyStimulus(64'h0000_0000_0000_EEFF, 4'd2, 1'b0);
        applyStimulus(64'h5A5A_5A5A_5A5A_1122, 4'd2, 1'b1);
        waitDrain();
        check("pack4_data", last_data, 64'hAABB_CCDD_EEFF_1122);
        check("pack4_be", 64'(last_be), 64'hFF);
        check("pack4_last", 64'(last_last), 64'd1);

        applyStimulus(64'hEEEE_EE01_0203_0405, 4'd5, 1'b0);
        applyStimulus(64'h0000_0006_0708_090A, 4'd5, 1'b1);
        @(negedge clk);
        check("flush_s_ready", 64'(bus.s_ready), 64'd0);
        waitDrain();
        check("flush_data", last_data, 64'h090A_0000_0000_0000);
        check("flush_be", 64'(last_be), 64'hC0);
        check("flush_last", 64'(last_last), 64'd1);

        ready_mode = 2;
        repeat (2) @(posedge clk);
        #1;
        applyStimulus(64'h0102_0304_0506_0708, 4'd8, 1'b0);
        fork
            applyStimulus(64'h1112_1314_1516_1718, 4'd8, 1'b1);
            begin
                for (int i = 0; i < 5; i++) begin
                    @(negedge clk);
                    check("stall_s_ready", 64'(bus.s_ready), 64'd0);
                    check("stall_m_data", bus.m_data, 64'h0102_0304_0506_0708);
                end
                ready_mode = 0;
            end
        join
        waitDrain();
        check("stall_tail_data", last_data, 64'h1112_1314_1516_1718);

        applyStimulus(64'hFFFF_FFFF_FFFF_FFFF, 4'd0, 1'b1);
        waitDrain();
        check("empty_be", 64'(last_be), 64'h00);
        check("empty_last", 64'(last_last), 64'd1);

        applyStimulus(64'h0000_0000_00A1_A2A3, 4'd3, 1'b0);
        #3;
        rst_n = 1'b0;
        #1;
        check("arst_m_valid", 64'(bus.m_valid), 64'd0);
        check("arst_s_ready", 64'(bus.s_ready), 64'd0);
        check("arst_m_data", bus.m_data, 64'd0);
        check("arst_m_last", 64'(bus.m_last), 64'd0);
        pkt_q.delete();
        exp_q.delete();
        repeat (2) @(negedge clk);
        @(posedge clk);
        #3;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        beats_before = beat_count;
        applyStimulus(64'hC1C2_C3C4_C5C6_C7C8, 4'd8, 1'b1);
        waitDrain();
        check("after_rst_beats", 64'(beat_count - beats_before), 64'd1);
        check("after_rst_be", 64'(last_be), 64'hFF);
        check("after_rst_data", last_data, 64'hC1C2_C3C4_C5C6_C7C8);

`ifdef DABUS_PACK_ERRCHK_EN
        errs_before = err_count;
        for (int b = 0; b < 5; b++) begin
            applyStimulus({$urandom, $urandom}, 4'd8, b == 4);
        end
        waitDrain();
        check("err_oversize_count", 64'(err_count - errs_before), 64'd1);
        errs_before = err_count;
        applyStimulus({$urandom, $urandom}, 4'd8, 1'b0);
        applyStimulus({$urandom, $urandom}, 4'd8, 1'b1);
        waitDrain();
        check("err_next_pkt_count", 64'(err_count - errs_before), 64'd0);
`endif

        ready_mode = 1;
        for (int p = 0; p < 40; p++) begin
            nbeats = $urandom_range(1, 6);
            for (int b = 0; b < nbeats; b++) begin
                d  = {$urandom, $urandom};
                nb = ($urandom_range(0, 9) == 0) ? 4'($urandom_range(9, 15)) : 4'($urandom_range(0, 8));
                applyStimulus(d, nb, b == nbeats - 1);
                if ($urandom_range(0, 3) == 0) begin
                    repeat ($urandom_range(1, 3)) @(posedge clk);
                    #1;
                end
            end
        end
        waitDrain();
        ready_mode = 0;
        repeat (3) @(posedge clk);
        check("final_queue_empty", 64'(exp_q.size()), 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests, failures);
        $finish;
    end

endmodule

// File: doc/dabus_pack.md
DABUS_PACK -- requirements
Module: dabus_pack

Interface
REQ-001 Parameter: MAX_PKT_BEATS, default 32, maximum output beats per packet (256-byte SRIO payload); used only when DABUS_PACK_ERRCHK_EN is defined.
REQ-002 clk  input  1  single clock; all logic rising-edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 s_valid  input  1  input beat valid.
REQ-005 s_ready  output  1  input beat accepted when s_valid && s_ready.
REQ-006 s_data  input  64  LSB-aligned bytes; valid bytes are s_data[8*s_nbytes-1:0]; the most significant valid byte is first in stream order.
REQ-007 s_nbytes  input  4  valid byte count, 0..8; values above 8 are treated as 8.
REQ-008 s_last  input  1  final input beat of packet.
REQ-009 m_valid  output  1  output beat valid.
REQ-010 m_ready  input  1  output beat consumed when m_valid && m_ready.
REQ-011 m_data  output  64  MSB-aligned packed bytes; first stream byte at [63:56]; unused bytes zero.
REQ-012 m_be  output  8  byte enable; bit 7 maps to [63:56]; always contiguous from bit 7.
REQ-013 m_last  output  1  final output beat of packet.
REQ-014 err  output  1  one-cycle oversize pulse; present only with DABUS_PACK_ERRCHK_EN.

Function
REQ-015 Block SHALL pack variable-length LSB-aligned input into full MSB-aligned 8-byte words; this is the inverse of the byte-enable-driven right-justify used on the receive path.
REQ-016 Residual register acc holds f bytes (0..7), MSB-aligned; f is 0 after reset and after every m_last handshake.
REQ-017 Output SHALL be a single register stage; m_valid asserts the cycle after the input beat that produces it is accepted.
REQ-018 s_ready = (state==PACK) && (!m_valid || m_ready).
REQ-019 State PACK, accept of n bytes with f+n<8 and !s_last: append to acc, f+=n, no output beat.
REQ-020 State PACK, accept with f+n>=8: output the first 8 bytes of acc||input, m_be=8'hFF, retain f+n-8 bytes; m_last=1 only if s_last && f+n==8.
REQ-021 State PACK, accept with s_last && f+n<8: output acc||input, m_be has f+n ones from bit 7, m_last=1, f=0.
REQ-022 State PACK, accept with s_last && f+n>8: emit the full word per REQ-020, then go to FLUSH.
REQ-023 State FLUSH: load the residual (f bytes) as the final beat with m_last=1 once the output register is free; f=0; return to PACK. s_ready=0 while in FLUSH.
REQ-024 A beat with s_nbytes=0 and !s_last SHALL be accepted with no effect. A beat with s_nbytes=0 and s_last and f=0 SHALL emit m_be=8'h00, m_last=1.
REQ-025 m_data, m_be and m_last SHALL hold stable while m_valid && !m_ready.

Reset
REQ-026 Reset asserted at any time, including mid-packet or in FLUSH, SHALL clear state to PACK, f=0, acc=0, and all outputs to 0 (m_valid, m_data, m_be, m_last, err, s_ready). Partial data is discarded.

Configuration
REQ-027 Macro DABUS_PACK_ERRCHK_EN defined: a beat counter counts output beats per packet. On the beat that makes the count exceed MAX_PKT_BEATS, err SHALL pulse high for 1 cycle. The counter then saturates and clears on the m_last handshake. Data flow is unaffected.
REQ-028 Macro undefined: no counter and no err port.

Structure
REQ-029 Shared package dabus_pkg SHALL hold the state encoding (PACK, FLUSH), BYTES_PER_BEAT=8, and a byte-count-to-MSB-contiguous-enable function.
REQ-030 One sub-module, dabus_be_gen (count 0..8 -> m_be), is natural. The rest is flat.

Verification
REQ-031 Four beats of nbytes=2 (AA BB, CC DD, EE FF, 11 22), last on the 4th -> one beat m_data=AABBCCDDEEFF1122, m_be=FF, m_last=1.
REQ-032 nbytes=5, then nbytes=5 with last -> beat 1 m_be=FF; FLUSH beat m_be=C0, m_last=1; s_ready=0 for the FLUSH cycle.
REQ-033 m_ready held low for 5 cycles with an output pending -> m_data stable, s_ready=0, no input lost.
REQ-034 Single beat nbytes=0 with last -> m_be=00, m_last=1.
REQ-035 rst_n dropped while f=3 -> outputs 0 immediately. A following packet of 8 bytes -> exactly one beat, m_be=FF.
REQ-036 With DABUS_PACK_ERRCHK_EN and MAX_PKT_BEATS=4: 5 full beats -> err high on the 5th output beat only; the next packet produces no err.
